mem_bus_responder: RTL



---
 rtl/mem_bus_responder.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side responder for a MAR/MDR strobe bus with programmable wait states
// Ports: clk/rst (async active-low) | rd, wr, addr, wdata: single-cycle request strobe
//        rdata: last read result | ack/err: one-cycle completion pulses
//        busy: access in flight or queued | overrun: sticky dropped-request flag
module mem_bus_responder #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic              overrun
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = WAIT_CYC > 1 ? $clog2(WAIT_CYC) : 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACCESS = 2'd2;
    localparam logic [1:0] S_LAUNCH = WAIT_CYC == 0 ? S_ACCESS : S_WAIT;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYC - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              cur_rd, cur_wr, slot_valid, slot_rd, slot_wr;
    logic [ADDR_W-1:0] cur_addr, slot_addr;
    logic [DATA_W-1:0] cur_wdata, slot_wdata;
    logic              req, in_range, illegal;

    assign req      = rd | wr;
    assign in_range = {1'b0, cur_addr} < (ADDR_W + 1)'(DEPTH);
    assign illegal  = cur_rd & cur_wr;
    assign busy     = (state != S_IDLE) | slot_valid;

    always_ff @(posedge clk)
        if (state == S_ACCESS && cur_wr && !cur_rd && in_range)
            mem[cur_addr[AW-1:0]] <= cur_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cur_rd     <= 1'b0;
            cur_wr     <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            slot_valid <= 1'b0;
            slot_rd    <= 1'b0;
            slot_wr    <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            rdata      <= '0;
            ack        <= 1'b0;
            err        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                S_IDLE: if (req) begin
                    {cur_rd, cur_wr, cur_addr, cur_wdata} <= {rd, wr, addr, wdata};
                    state <= S_LAUNCH;
                    cnt   <= CNT_INIT;
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_ACCESS;
                    else cnt <= cnt - 1'b1;
                    if (req && slot_valid) overrun <= 1'b1;
                    else if (req) begin
                        {slot_rd, slot_wr, slot_addr, slot_wdata} <= {rd, wr, addr, wdata};
                        slot_valid <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    ack <= 1'b1;
                    err <= illegal | !in_range;
                    if (cur_rd && !cur_wr) rdata <= in_range ? mem[cur_addr[AW-1:0]] : '0;
                    // The queued request launches now; a request arriving on this
                    // same edge takes the freed slot, or launches directly if no
                    // slot was waiting so its latency is not stretched by an IDLE cycle.
                    if (slot_valid) begin
                        {cur_rd, cur_wr, cur_addr, cur_wdata} <= {slot_rd, slot_wr, slot_addr, slot_wdata};
                        state      <= S_LAUNCH;
                        cnt        <= CNT_INIT;
                        slot_valid <= req;
                        if (req) {slot_rd, slot_wr, slot_addr, slot_wdata} <= {rd, wr, addr, wdata};
                    end else if (req) begin
                        {cur_rd, cur_wr, cur_addr, cur_wdata} <= {rd, wr, addr, wdata};
                        state <= S_LAUNCH;
                        cnt   <= CNT_INIT;
                    end else state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
